// File: rtl/ex_mem_pipe_pkg.sv
// rtl/ex_mem_pipe_pkg.sv - shared core configuration, memory opcodes and EX/MEM entry type
package ex_mem_pipe_pkg;

  localparam int XLEN          = 64;
  localparam int REG_ADDRWIDTH = 5;
  localparam int MEMOP_LEN     = 4;

  localparam logic [XLEN-1:0] PC_RESET_ADDR = 64'h0000_0000_8000_0000;

  typedef enum logic [MEMOP_LEN-1:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LB   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LW   = 4'd3,
    MEMOP_LD   = 4'd4,
    MEMOP_LBU  = 4'd5,
    MEMOP_LHU  = 4'd6,
    MEMOP_LWU  = 4'd7,
    MEMOP_SB   = 4'd8,
    MEMOP_SH   = 4'd9,
    MEMOP_SW   = 4'd10,
    MEMOP_SD   = 4'd11
  } mem_op_e;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [REG_ADDRWIDTH-1:0] rd_idx;
    logic [XLEN-1:0]          rs2_data;
    logic [MEMOP_LEN-1:0]     mem_op;
    logic [XLEN-1:0]          exc;
    logic                     misalign;
  } entry_t;

  // Access size in bytes; non-memory ops count as byte-sized so they never misalign.
  function automatic logic [3:0] memop_size(input logic [MEMOP_LEN-1:0] op);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return 4'd2;
      MEMOP_LW, MEMOP_LWU, MEMOP_SW: return 4'd4;
      MEMOP_LD, MEMOP_SD:            return 4'd8;
      default:                       return 4'd1;
    endcase
  endfunction

  function automatic logic addr_misaligned(input logic [MEMOP_LEN-1:0] op,
                                           input logic [2:0]           addr_lo);
    logic [3:0] mask;
    mask = memop_size(op) - 4'd1;
    return |({1'b0, addr_lo} & mask);
  endfunction

endpackage

// File: rtl/ex_mem_pipe_if.sv
// rtl/ex_mem_pipe_if.sv - execute-side and memory-side handshake bundle of the EX/MEM pipe
interface ex_mem_pipe_if;
  import ex_mem_pipe_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_pc;
  logic [REG_ADDRWIDTH-1:0] in_rd_idx;
  logic [XLEN-1:0]          in_rs2_data;
  logic [MEMOP_LEN-1:0]     in_mem_op;
  logic [XLEN-1:0]          in_exc;

  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_pc;
  logic [REG_ADDRWIDTH-1:0] out_rd_idx;
  logic [XLEN-1:0]          out_rs2_data;
  logic [MEMOP_LEN-1:0]     out_mem_op;
  logic [XLEN-1:0]          out_exc;
  logic                     out_misalign;

  modport master (
    output in_valid, in_pc, in_rd_idx, in_rs2_data, in_mem_op, in_exc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd_idx, out_rs2_data, out_mem_op,
           out_exc, out_misalign
  );

  modport slave (
    input  in_valid, in_pc, in_rd_idx, in_rs2_data, in_mem_op, in_exc, out_ready,
    output in_ready, out_valid, out_pc, out_rd_idx, out_rs2_data, out_mem_op,
           out_exc, out_misalign
  );
endinterface

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - one EX/MEM payload register with load enable
module pipe_entry_reg
  import ex_mem_pipe_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  entry_t d,
  output entry_t q
);

  entry_t entry_d;
  entry_t entry_q;

  always_comb begin
    entry_d = entry_q;
    if (load) entry_d = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) entry_q <= '0;
    else      entry_q <= entry_d;
  end

  assign q = entry_q;

endmodule

// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with 2-entry skid buffer and registered in_ready
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  ex_mem_pipe_if.slave bus
);

  logic   main_valid_d, main_valid_q;
  logic   skid_valid_d, skid_valid_q;
  logic   load_main, load_skid, main_from_skid;
  logic   accept, consume;
  entry_t in_entry, main_src, main_q, skid_q;

  always_comb begin
    in_entry          = '0;
    in_entry.pc       = bus.in_pc;
    in_entry.rd_idx   = bus.in_rd_idx;
    in_entry.rs2_data = bus.in_rs2_data;
    in_entry.mem_op   = bus.in_mem_op;
    in_entry.exc      = bus.in_exc;
    in_entry.misalign = addr_misaligned(bus.in_mem_op, bus.in_exc[2:0]);
  end

  assign accept  = bus.in_valid & ~skid_valid_q;
  assign consume = main_valid_q & bus.out_ready;

  // Skid full implies in_ready=0, so no accept can coincide with a skid refill.
  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      if (consume) begin
        load_main      = 1'b1;
        main_from_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      load_main    = accept;
      main_valid_d = accept;
    end else if (accept) begin
      load_skid    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign main_src = main_from_skid ? skid_q : in_entry;

  pipe_entry_reg u_main (
    .clk  (clk),
    .rst  (rst),
    .load (load_main),
    .d    (main_src),
    .q    (main_q)
  );

  pipe_entry_reg u_skid (
    .clk  (clk),
    .rst  (rst),
    .load (load_skid),
    .d    (in_entry),
    .q    (skid_q)
  );

  assign bus.in_ready     = ~skid_valid_q;
  assign bus.out_valid    = main_valid_q;
  assign bus.out_pc       = main_q.pc;
  assign bus.out_rd_idx   = main_q.rd_idx;
  assign bus.out_rs2_data = main_q.rs2_data;
  assign bus.out_mem_op   = main_valid_q ? main_q.mem_op : MEMOP_NONE;
  assign bus.out_exc      = main_q.exc;
  assign bus.out_misalign = main_q.misalign;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - scoreboard bench for the EX/MEM pipe
module tb_ex_mem_pipe;
  import ex_mem_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   seq      = 0;

  entry_t sb[$];

  ex_mem_pipe_if bus ();

  ex_mem_pipe dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic exp_mis(input logic [3:0] op, input logic [63:0] a);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return a[0];
      MEMOP_LW, MEMOP_LWU, MEMOP_SW: return a[1] | a[0];
      MEMOP_LD, MEMOP_SD:            return a[2] | a[1] | a[0];
      default:                       return 1'b0;
    endcase
  endfunction

  // Monitor: pops the oldest expected op whenever the memory stage consumes.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (!bus.out_valid) check("memop_none_idle", 64'(bus.out_mem_op), 64'(MEMOP_NONE));
      if (flush) begin
        sb.delete();
      end else if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output_pc", bus.out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          entry_t e;
          e = sb.pop_front();
          check("out_pc",       bus.out_pc,              e.pc);
          check("out_rd_idx",   64'(bus.out_rd_idx),     64'(e.rd_idx));
          check("out_rs2_data", bus.out_rs2_data,        e.rs2_data);
          check("out_mem_op",   64'(bus.out_mem_op),     64'(e.mem_op));
          check("out_exc",      bus.out_exc,             e.exc);
          check("out_misalign", 64'(bus.out_misalign),   64'(e.misalign));
        end
      end
    end
  end

  task automatic drive(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] rs2,
                       input logic [3:0] op, input logic [63:0] exc);
    bus.in_valid    = 1'b1;
    bus.in_pc       = pc;
    bus.in_rd_idx   = rd;
    bus.in_rs2_data = rs2;
    bus.in_mem_op   = op;
    bus.in_exc      = exc;
  endtask

  task automatic push(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] rs2,
                      input logic [3:0] op, input logic [63:0] exc, input logic mis);
    entry_t e;
    e.pc = pc; e.rd_idx = rd; e.rs2_data = rs2; e.mem_op = op; e.exc = exc; e.misalign = mis;
    sb.push_back(e);
  endtask

  // Returns at the negedge before the accepting edge; the caller must send or idle next.
  task automatic send(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] rs2,
                      input logic [3:0] op, input logic [63:0] exc, input logic mis);
    int  waited;
    logic ok;
    waited = 0;
    @(posedge clk); #1;
    drive(pc, rd, rs2, op, exc);
    do begin
      @(negedge clk);
      ok = bus.in_ready && !flush;
      if (!ok) begin
        waited++;
        @(posedge clk); #1;
      end
    end while (!ok && waited < 20);
    if (ok) push(pc, rd, rs2, op, exc, mis);
    else    check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    bus.out_ready = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(64'hDEAD, 5'd3, 64'h1, MEMOP_LW, 64'h40);
    repeat (3) begin
      @(negedge clk);
      check("rst_out_valid",  64'(bus.out_valid),  64'd0);
      check("rst_out_mem_op", 64'(bus.out_mem_op), 64'(MEMOP_NONE));
      check("rst_out_pc",     bus.out_pc,          64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

    // Streaming: one op per cycle, latency 1
    for (int k = 0; k < 8; k++) begin
      send(64'h8000_0000 + 64'(4 * k), 5'(k + 1), 64'h1111 * 64'(k),
           (k % 2 == 1) ? MEMOP_SW : MEMOP_LW, 64'h1000 + 64'(8 * k), 1'b0);
      check("stream_in_ready", 64'(bus.in_ready), 64'd1);
      if (k > 0) begin
        check("stream_out_valid", 64'(bus.out_valid), 64'd1);
        check("stream_latency_pc", bus.out_pc, 64'h8000_0000 + 64'(4 * (k - 1)));
      end
    end
    idle();
    @(negedge clk);
    check("stream_last_pc", bus.out_pc, 64'h8000_001C);
    @(negedge clk);
    check("stream_drained_valid", 64'(bus.out_valid), 64'd0);
    check("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: A in main, B in skid
    set_ready(1'b0);
    send(64'h8000_0000, 5'd1, 64'hA, MEMOP_LW, 64'h2000, 1'b0);
    send(64'h8000_0004, 5'd2, 64'hB, MEMOP_SW, 64'h8000_0002, 1'b1);
    idle();
    @(negedge clk);
    check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_hold_pc_a",    bus.out_pc,        64'h8000_0000);
    set_ready(1'b1);
    @(negedge clk);
    check("bp_in_ready_still_low", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    check("bp_pc_b",          bus.out_pc,        64'h8000_0004);
    check("bp_misalign_b",    64'(bus.out_misalign), 64'd1);
    @(negedge clk);
    check("bp_drained", 64'(bus.out_valid), 64'd0);

    // Misalignment per access size, plus an ALU-only op carried through
    send(64'h8000_0010, 5'd4, 64'h0, MEMOP_SD,   64'h8000_0008, 1'b0);
    send(64'h8000_0014, 5'd5, 64'h0, MEMOP_LB,   64'h8000_0003, 1'b0);
    send(64'h8000_0018, 5'd6, 64'h0, MEMOP_LH,   64'h8000_0001, 1'b1);
    send(64'h8000_001C, 5'd7, 64'h0, MEMOP_LD,   64'h8000_0004, 1'b1);
    send(64'h8000_0020, 5'd8, 64'h0, MEMOP_LWU,  64'h8000_0004, 1'b0);
    send(64'h8000_0024, 5'd9, 64'h0, MEMOP_NONE, 64'h0000_0007, 1'b0);
    idle();
    repeat (3) @(negedge clk);
    check("mis_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with both entries full and a new op presented
    set_ready(1'b0);
    send(64'h8000_0100, 5'd10, 64'h1, MEMOP_LD, 64'h10, 1'b0);
    send(64'h8000_0104, 5'd11, 64'h2, MEMOP_SD, 64'h18, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    drive(64'h9000_0000, 5'd12, 64'h3, MEMOP_SW, 64'h20);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_out_valid",  64'(bus.out_valid),  64'd0);
    check("flush_out_mem_op", 64'(bus.out_mem_op), 64'(MEMOP_NONE));
    check("flush_in_ready",   64'(bus.in_ready),   64'd1);
    set_ready(1'b1);
    repeat (4) begin
      @(negedge clk);
      check("flush_no_ghost", 64'(bus.out_valid), 64'd0);
    end

    // Random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      logic [3:0]  op;
      logic [63:0] exc, rs2, pc;
      logic [4:0]  rd;
      @(posedge clk); #1;
      flush         = ($urandom_range(0, 63) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      op  = 4'($urandom_range(0, 11));
      exc = {$urandom, $urandom};
      rs2 = {$urandom, $urandom};
      rd  = 5'($urandom_range(0, 31));
      pc  = 64'h8000_0000 + 64'(4 * seq);
      drive(pc, rd, rs2, op, exc);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (bus.in_valid && bus.in_ready && !flush) begin
        push(pc, rd, rs2, op, exc, exp_mis(op, exc));
        seq++;
      end
    end
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int w = 0; w < 10; w++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) break;
    end
    @(negedge clk);
    check("rand_sb_empty",  64'(sb.size()),     64'd0);
    check("rand_out_valid", 64'(bus.out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
Name: ex_mem_pipe

Overview:
- Pipeline register between the execute stage and the memory-access stage of the RV64 core.
- Holds each execute result together with the operands the memory stage consumes: pc, rd_idx, rs2_data, mem_op and the ALU/address result.
- Uses a 2-entry skid buffer so that the ready signal toward execute is registered while throughput stays at one op per cycle.
- Forces mem_op to MEMOP_NONE whenever no valid op is presented, so the memory stage never issues a spurious pmem access. Flags misaligned load/store addresses.

Parameters:
- XLEN, 64, datapath width.
- REG_ADDRWIDTH, 5, register index width.
- MEMOP_LEN, 4, memory opcode width; encodings come from the shared package.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  execute presents an op.
- in_ready  out  1  pipe can accept; registered.
- in_pc  in  XLEN  instruction pc.
- in_rd_idx  in  REG_ADDRWIDTH  destination register.
- in_rs2_data  in  XLEN  store data.
- in_mem_op  in  MEMOP_LEN  memory opcode.
- in_exc  in  XLEN  execute result / effective address.
- out_valid  out  1  op presented to memory stage.
- out_ready  in  1  memory stage consumes.
- out_pc  out  XLEN  held pc.
- out_rd_idx  out  REG_ADDRWIDTH  held rd.
- out_rs2_data  out  XLEN  held store data.
- out_mem_op  out  MEMOP_LEN  held opcode; MEMOP_NONE when out_valid=0.
- out_exc  out  XLEN  held result/address.
- out_misalign  out  1  held op's address is misaligned for its access size.

Behaviour:
- Reset (rst=0, asynchronous):
  - main_valid=0, skid_valid=0.
  - All payload registers are 0, and out_mem_op=MEMOP_NONE.
  - in_ready=1 from the first cycle after rst deasserts.
- Storage: main entry (drives outputs) and skid entry. Each entry holds pc, rd_idx, rs2_data, mem_op, exc and misalign.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready = ~skid_valid. This is a register output with no combinational path from out_ready.
- out_valid = main_valid.
- out_mem_op = main_valid ? main.mem_op : MEMOP_NONE. The other payload outputs show main contents regardless of valid.
- Transitions at each clock edge, with flush=0:
  - Main empty and accept: load the input into main. Latency 1 cycle: input at edge N appears on outputs after edge N.
  - Main full, consume and accept, skid empty: load the input into main.
  - Main full, no consume, accept: load the input into skid. in_ready drops next cycle.
  - Skid full and consume: move skid into main and clear skid.
  - Main full, consume, no accept, skid empty: main becomes empty.
- Ordering is strictly FIFO. An op is never duplicated or dropped without flush.
- Misalign is computed from in_exc when the op is captured:
  - Half-word ops (LH/LHU/SH): exc[0] != 0.
  - Word ops (LW/LWU/SW): exc[1:0] != 0.
  - Double-word ops (LD/SD): exc[2:0] != 0.
  - Byte ops and MEMOP_NONE: always 0.
- Flush (flush=1 at an edge):
  - main_valid and skid_valid clear.
  - An input accepted in the same cycle is discarded. Flush wins over accept and over consume.
  - Next cycle: out_valid=0, out_mem_op=MEMOP_NONE, in_ready=1.
- An op with in_mem_op=MEMOP_NONE (ALU-only instruction) is carried like any other op.
- Reset asserted mid-operation discards both entries immediately, asynchronously.

Decomposition:
- Shared package (sysconfig): XLEN, REG_ADDRWIDTH, MEMOP_LEN, all MEMOP_* encodings, PC_RESET_ADDR.
- Add a package function or macro mapping a mem_op to its access size (1/2/4/8 bytes) for the misalign check.
- Sub-module: pipe_entry_reg, a single payload register with load enable and asynchronous active-low reset.
  - Instantiated twice (main, skid).
  - The top level holds only the valid bits and the control logic.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, out_mem_op=MEMOP_NONE, and in_ready=1 after release.
- Streaming: 8 ops (pc 0x80000000 + 4k) with out_ready=1 every cycle -> one output per cycle, in order, latency 1, in_ready stays 1.
- Backpressure:
  - Accept op A (pc 0x80000000), then op B (pc 0x80000004) with out_ready=0 -> in_ready=0 in the next cycle.
  - Raise out_ready -> A then B are emitted, and in_ready returns to 1 after skid drains.
- Misalign: SW with exc=0x80000002 -> out_misalign=1. SD with exc=0x80000008 -> out_misalign=0. LB with exc=0x80000003 -> out_misalign=0.
- Flush: with both entries full, pulse flush together with in_valid=1 -> next cycle out_valid=0, out_mem_op=MEMOP_NONE, in_ready=1, and no flushed pc appears afterwards.
- Random: randomized in_valid/out_ready/flush for 10k cycles against a scoreboard FIFO -> no loss, no duplication, order preserved.
